hfrv_trace_capture: RTL and testbench

//  Triggered bus-trace capture unit on the HF-RISC core memory bus, between dut_top's core bus and the verification monitor.
//  - Timestamps qualified fetch/load/store events and buffers them in a FIFO.
//  - Presents the buffered events on a valid/ready drain port.
//  - Lets the monitor callbacks consume bus activity from hardware, including on FPGA builds.

---
 rtl/hfrv_trace_pkg.sv | 36 +++
 rtl/hfrv_trace_fifo.sv | 84 ++++++++
 rtl/hfrv_trace_capture.sv | 199 +++++++++++++++++++
 tb/tb_hfrv_trace_capture.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hfrv_trace_pkg.sv
// Shared types for the HF-RISC bus-trace capture unit.
//   trace_kind_e  : bus event kinds carried in a record (2'b11 is reserved, never captured)
//   trace_state_e : capture FSM states, also the encoding seen on state_o
//   trace_rec_t   : one captured record, {kind, addr, data, be, stamp}
//   is_qualified  : a bus beat is a traceable event when valid, not stalled, not reserved
package hfrv_trace_pkg;

  localparam int TRACE_REC_W = 102;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } trace_kind_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] stamp;
  } trace_rec_t;

  function automatic logic is_qualified(input logic valid, input logic stall,
                                        input logic [1:0] kind);
    return valid & ~stall & (kind != 2'b11);
  endfunction

endpackage

// File: rtl/hfrv_trace_fifo.sv
// First-word-fall-through FIFO for trace records.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous flush, wins over push/pop in the same cycle
//   push/wdata : write request; accepted when not full, or when full and a pop happens too
//   pop        : consume the head entry; ignored while empty
//   rdata      : head entry, valid whenever empty=0
//   full/empty : occupancy flags
module hfrv_trace_fifo #(
  parameter int WIDTH = 102,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == {CW{1'b0}});

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Head entry is read straight out of storage (fall-through).
  assign rdata = mem_r[rd_ptr_r];

  // Record storage; reset to zero so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/hfrv_trace_capture.sv
// Triggered bus-trace capture on the HF-RISC core memory bus.
// Qualified fetch/load/store events are timestamped with a free-running cycle
// counter and pushed into a FWFT FIFO once the trigger address has been seen;
// capture stops after POST_COUNT events (trigger included).
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   arm_i                  : IDLE/DONE -> ARMED
//   clear_i                : flush FIFO, zero post/drop counters, go IDLE (beats arm_i)
//   trig_addr_i            : trigger address
//   bus_valid_i/stall_i/kind_i/addr_i/data_i/be_i : core bus event
//   rec_valid_o/rec_ready_i/rec_o : record drain port, {kind, addr, data, be, stamp}
//   state_o                : FSM state
//   drops_o / overflow_o   : saturating count of events lost to a full FIFO / sticky flag
module hfrv_trace_capture
  import hfrv_trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int POST_COUNT = 64,
  parameter int DROP_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   arm_i,
  input  logic                   clear_i,
  input  logic [31:0]            trig_addr_i,
  input  logic                   bus_valid_i,
  input  logic                   bus_stall_i,
  input  logic [1:0]             bus_kind_i,
  input  logic [31:0]            bus_addr_i,
  input  logic [31:0]            bus_data_i,
  input  logic [3:0]             bus_be_i,
  output logic                   rec_valid_o,
  input  logic                   rec_ready_i,
  output logic [TRACE_REC_W-1:0] rec_o,
  output logic [1:0]             state_o,
  output logic [DROP_W-1:0]      drops_o,
  output logic                   overflow_o
);

  localparam int PW = $clog2(POST_COUNT + 1);
  localparam logic [PW-1:0]     POST_ONE  = PW'(1);
  localparam logic [PW-1:0]     POST_LAST = PW'(POST_COUNT);
  localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

  trace_state_e state_r;
  trace_state_e state_next_s;
  logic [PW-1:0]     post_r;
  logic [PW-1:0]     post_next_s;
  logic [PW-1:0]     post_inc_s;
  logic [31:0]       stamp_r;
  logic [DROP_W-1:0] drops_r;
  logic              overflow_r;
  logic              qual_s;
  logic              capture_s;
  logic              pop_s;
  logic              drop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  trace_rec_t        rec_s;

  assign qual_s     = is_qualified(bus_valid_i, bus_stall_i, bus_kind_i);
  assign post_inc_s = post_r + POST_ONE;

  // Record formatting; byte enables only mean something for stores.
  always_comb begin
    rec_s.kind  = bus_kind_i;
    rec_s.addr  = bus_addr_i;
    rec_s.data  = bus_data_i;
    rec_s.stamp = stamp_r;
    if (bus_kind_i == STORE) begin
      rec_s.be = bus_be_i;
    end else begin
      rec_s.be = 4'b0000;
    end
  end

  // Next-state, post counter and capture decision; clear_i overrides everything.
  always_comb begin
    state_next_s = state_r;
    post_next_s  = post_r;
    capture_s    = 1'b0;
    if (clear_i) begin
      state_next_s = IDLE;
      post_next_s  = {PW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (arm_i) begin
            state_next_s = ARMED;
          end else begin
            state_next_s = IDLE;
          end
        end
        ARMED: begin
          if (qual_s && (bus_addr_i == trig_addr_i)) begin
            capture_s   = 1'b1;
            post_next_s = POST_ONE;
            if (POST_COUNT <= 1) begin
              state_next_s = DONE;
            end else begin
              state_next_s = CAPTURE;
            end
          end else begin
            state_next_s = ARMED;
          end
        end
        CAPTURE: begin
          if (qual_s) begin
            capture_s   = 1'b1;
            post_next_s = post_inc_s;
            if (post_inc_s == POST_LAST) begin
              state_next_s = DONE;
            end else begin
              state_next_s = CAPTURE;
            end
          end else begin
            state_next_s = CAPTURE;
          end
        end
        DONE: begin
          if (arm_i) begin
            state_next_s = ARMED;
          end else begin
            state_next_s = DONE;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // FSM state and post counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      post_r  <= {PW{1'b0}};
    end else begin
      state_r <= state_next_s;
      post_r  <= post_next_s;
    end
  end

  // Free-running timestamp; clear_i deliberately leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stamp_r <= 32'd0;
    end else begin
      stamp_r <= stamp_r + 32'd1;
    end
  end

  assign pop_s  = rec_valid_o & rec_ready_i;
  // Full FIFO only loses the event when nothing leaves in the same cycle.
  assign drop_s = capture_s & fifo_full_s & ~pop_s;

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drops_r    <= {DROP_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (clear_i) begin
      drops_r    <= {DROP_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drops_r != DROP_MAX) begin
        drops_r <= drops_r + DROP_ONE;
      end else begin
        drops_r <= drops_r;
      end
    end else begin
      drops_r    <= drops_r;
      overflow_r <= overflow_r;
    end
  end

  hfrv_trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (clear_i),
    .push  (capture_s),
    .wdata (rec_s),
    .pop   (pop_s),
    .rdata (rec_o),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign rec_valid_o = ~fifo_empty_s;
  assign state_o     = state_r;
  assign drops_o     = drops_r;
  assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_hfrv_trace_capture.sv
// Self-checking bench for hfrv_trace_capture (DEPTH=4, POST_COUNT=6).
// A queue-based reference model tracks records, state, post count, drops and the
// timestamp; directed tables and sequences add checks against fixed constants.
module tb_hfrv_trace_capture;

  localparam int DEPTH = 4;
  localparam int PC    = 6;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         arm, clear;
  logic [31:0]  trig_addr;
  logic         bus_valid, bus_stall;
  logic [1:0]   bus_kind;
  logic [31:0]  bus_addr, bus_data;
  logic [3:0]   bus_be;
  logic         rec_valid, rec_ready;
  logic [101:0] rec;
  logic [1:0]   state;
  logic [15:0]  drops;
  logic         overflow;

  hfrv_trace_capture #(.DEPTH(DEPTH), .POST_COUNT(PC), .DROP_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .arm_i(arm), .clear_i(clear),
    .trig_addr_i(trig_addr), .bus_valid_i(bus_valid), .bus_stall_i(bus_stall),
    .bus_kind_i(bus_kind), .bus_addr_i(bus_addr), .bus_data_i(bus_data),
    .bus_be_i(bus_be), .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
    .rec_o(rec), .state_o(state), .drops_o(drops), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [101:0] mq[$];
  logic [1:0]   m_state;
  int           m_post;
  logic [15:0]  m_drops;
  logic         m_ovf;
  logic [31:0]  m_stamp;
  logic [31:0]  dut_pops[$];

  typedef struct {
    logic        arm, clear, valid, stall;
    logic [1:0]  kind;
    logic [31:0] addr, data;
    logic [3:0]  be;
    logic        ready;
    logic [1:0]  exp_state;
    logic        exp_valid;
    logic [1:0]  exp_kind;
    logic [31:0] exp_addr, exp_data;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 2'd0;
    m_post  = 0;
    m_drops = 16'd0;
    m_ovf   = 1'b0;
    m_stamp = 32'd0;
  endtask

  task automatic model_update();
    logic qual, cap;
    logic [101:0] r;
    qual = bus_valid && !bus_stall && (bus_kind != 2'b11);
    cap  = 1'b0;
    if (clear) begin
      mq.delete();
      m_post  = 0;
      m_drops = 16'd0;
      m_ovf   = 1'b0;
      m_state = 2'd0;
    end else begin
      if (mq.size() > 0 && rec_ready) void'(mq.pop_front());
      case (m_state)
        2'd0: if (arm) m_state = 2'd1;
        2'd1: if (qual && bus_addr == trig_addr) begin
                cap = 1'b1; m_post = 1;
                m_state = (m_post >= PC) ? 2'd3 : 2'd2;
              end
        2'd2: if (qual) begin
                cap = 1'b1; m_post++;
                if (m_post == PC) m_state = 2'd3;
              end
        default: if (arm) m_state = 2'd1;
      endcase
      if (cap) begin
        r = {bus_kind, bus_addr, bus_data, (bus_kind == 2'b10) ? bus_be : 4'b0000, m_stamp};
        if (mq.size() < DEPTH) mq.push_back(r);
        else begin
          if (m_drops != 16'hFFFF) m_drops++;
          m_ovf = 1'b1;
        end
      end
    end
    m_stamp++;
  endtask

  task automatic check_model();
    chk("valid", rec_valid, (mq.size() > 0));
    if (mq.size() > 0) chk("rec", rec, mq[0]);
    chk("state", state, m_state);
    chk("drops", drops, m_drops);
    chk("overflow", overflow, m_ovf);
  endtask

  // One clock: inputs already driven; record DUT pops, advance model, check at negedge.
  task automatic step();
    if (rec_valid === 1'b1 && rec_ready === 1'b1) dut_pops.push_back(rec[99:68]);
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic a, input logic c, input logic v, input logic s,
                       input logic [1:0] k, input logic [31:0] ad, input logic [31:0] d,
                       input logic [3:0] b, input logic rd);
    arm = a; clear = c; bus_valid = v; bus_stall = s; bus_kind = k;
    bus_addr = ad; bus_data = d; bus_be = b; rec_ready = rd;
  endtask

  task automatic ev(input logic [1:0] k, input logic [31:0] ad, input logic rd);
    drive(1'b0, 1'b0, 1'b1, 1'b0, k, ad, ad ^ 32'hA5A5_0000, 4'b1111, rd);
    step();
  endtask

  task automatic idle(input logic rd, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'b0000, rd);
      step();
    end
  endtask

  task automatic ctl(input logic a, input logic c);
    drive(a, c, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'b0000, 1'b0);
    step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, rec_valid, 1'b0);
    chk({tag, "_rec"}, rec, 102'd0);
    chk({tag, "_state"}, state, 2'd0);
    chk({tag, "_drops"}, drops, 16'd0);
    chk({tag, "_overflow"}, overflow, 1'b0);
  endtask

  logic [31:0] exp_ov[4];
  logic [31:0] exp_fp[5];

  initial begin
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,4'h0,1'b1, 2'd1,1'b0,2'b00,32'h0,32'h0,4'h0};
    vecs[1] = '{1'b0,1'b0,1'b1,1'b0,2'b00,32'h100,32'h1111_1111,4'hF,1'b1, 2'd2,1'b1,2'b00,32'h100,32'h1111_1111,4'h0};
    vecs[2] = '{1'b0,1'b0,1'b1,1'b0,2'b10,32'h200,32'hDEAD_BEEF,4'h3,1'b0, 2'd2,1'b1,2'b00,32'h100,32'h1111_1111,4'h0};
    vecs[3] = '{1'b0,1'b0,1'b1,1'b0,2'b01,32'h300,32'h3333_3333,4'hF,1'b1, 2'd2,1'b1,2'b10,32'h200,32'hDEAD_BEEF,4'h3};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b1,2'b00,32'h400,32'h4444_4444,4'hF,1'b1, 2'd2,1'b1,2'b01,32'h300,32'h3333_3333,4'h0};
    vecs[5] = '{1'b0,1'b0,1'b1,1'b0,2'b11,32'h500,32'h5555_5555,4'hF,1'b1, 2'd2,1'b0,2'b00,32'h0,32'h0,4'h0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,4'h0,1'b1, 2'd2,1'b0,2'b00,32'h0,32'h0,4'h0};
    exp_ov = '{32'h100, 32'h704, 32'h708, 32'h70C};
    exp_fp = '{32'h100, 32'h804, 32'h808, 32'h80C, 32'h810};

    trig_addr = 32'h100;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'b0000, 1'b0);
    rst_ni = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_ni = 1'b1;

    // Directed table: arm, trigger fetch, store/load byte enables, stall, reserved kind
    dut_pops.delete();
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].arm, vecs[i].clear, vecs[i].valid, vecs[i].stall, vecs[i].kind,
            vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].ready);
      step();
      chk($sformatf("tbl%0d_state", i), state, vecs[i].exp_state);
      chk($sformatf("tbl%0d_valid", i), rec_valid, vecs[i].exp_valid);
      chk($sformatf("tbl%0d_drops", i), drops, 16'd0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("tbl%0d_kind", i), rec[101:100], vecs[i].exp_kind);
        chk($sformatf("tbl%0d_addr", i), rec[99:68], vecs[i].exp_addr);
        chk($sformatf("tbl%0d_data", i), rec[67:36], vecs[i].exp_data);
        chk($sformatf("tbl%0d_be", i), rec[35:32], vecs[i].exp_be);
      end
    end

    // Post count: six more events, only enough to reach POST_COUNT are recorded
    for (int i = 0; i < 6; i++) ev(2'b00, 32'h600 + 32'(i * 4), 1'b1);
    idle(1'b1, 3);
    chk("post_records", dut_pops.size(), PC);
    chk("post_state", state, 2'd3);
    chk("post_drops", drops, 16'd0);

    // Overflow: ready low, six captured events into a 4-deep FIFO
    ctl(1'b0, 1'b1);
    ctl(1'b1, 1'b0);
    ev(2'b00, 32'h100, 1'b0);
    ev(2'b10, 32'h704, 1'b0);
    ev(2'b01, 32'h708, 1'b0);
    ev(2'b00, 32'h70C, 1'b0);
    ev(2'b00, 32'h710, 1'b0);
    ev(2'b00, 32'h714, 1'b0);
    chk("ovf_drops", drops, 16'd2);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_state", state, 2'd3);
    dut_pops.delete();
    idle(1'b1, 6);
    chk("ovf_count", dut_pops.size(), 4);
    for (int i = 0; i < 4 && i < dut_pops.size(); i++)
      chk($sformatf("ovf_order%0d", i), dut_pops[i], exp_ov[i]);

    // Full FIFO with simultaneous push and pop
    ctl(1'b0, 1'b1);
    ctl(1'b1, 1'b0);
    dut_pops.delete();
    ev(2'b00, 32'h100, 1'b0);
    ev(2'b00, 32'h804, 1'b0);
    ev(2'b00, 32'h808, 1'b0);
    ev(2'b00, 32'h80C, 1'b0);
    ev(2'b01, 32'h810, 1'b1);
    chk("fullpp_drops", drops, 16'd0);
    chk("fullpp_ovf", overflow, 1'b0);
    idle(1'b1, 5);
    chk("fullpp_count", dut_pops.size(), 5);
    for (int i = 0; i < 5 && i < dut_pops.size(); i++)
      chk($sformatf("fullpp_order%0d", i), dut_pops[i], exp_fp[i]);

    // clear_i with arm_i in CAPTURE and a non-empty FIFO
    ctl(1'b0, 1'b1);
    ctl(1'b1, 1'b0);
    ev(2'b00, 32'h100, 1'b0);
    ev(2'b01, 32'h904, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h908, 32'h0, 4'b0000, 1'b1);
    step();
    chk("clr_state", state, 2'd0);
    chk("clr_valid", rec_valid, 1'b0);
    chk("clr_drops", drops, 16'd0);
    ctl(1'b1, 1'b0);
    ev(2'b00, 32'h100, 1'b1);
    idle(1'b1, 2);

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      arm       = ($urandom_range(7) == 0);
      clear     = ($urandom_range(63) == 0);
      bus_valid = ($urandom_range(1) == 1);
      bus_stall = ($urandom_range(5) == 0);
      bus_kind  = 2'($urandom_range(3));
      case ($urandom_range(3))
        0, 1:    bus_addr = 32'h100;
        2:       bus_addr = 32'h104;
        default: bus_addr = $urandom;
      endcase
      bus_data  = $urandom;
      bus_be    = 4'($urandom_range(15));
      rec_ready = ($urandom_range(1) == 1);
      trig_addr = ($urandom_range(15) == 0) ? 32'h104 : 32'h100;
      step();
    end
    trig_addr = 32'h100;

    // Reset in the middle of a capture with records pending
    ctl(1'b0, 1'b1);
    ctl(1'b1, 1'b0);
    ev(2'b00, 32'h100, 1'b0);
    ev(2'b10, 32'hA04, 1'b0);
    #2 rst_ni = 1'b0;
    #1 chk_reset_values("midrst");
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    ctl(1'b1, 1'b0);
    ev(2'b00, 32'h100, 1'b0);
    chk("midrst_stamp", rec[31:0], 32'd1);
    idle(1'b1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
